// File: rtl/booth_mul.sv
// ---------------------------------------------------------------------------
// booth_mul -- sequential signed Booth multiplier (WIDTH x WIDTH -> 2*WIDTH)
//
// Purpose:
//   Multiplies two signed operands by iterating Booth recoding steps over a
//   {Acc, Q, Q-1} shift register. Uses the same start/done handshake as the
//   non-restoring divider so both units are driven identically.
//
// Optional feature macro:
//   BOOTH_RADIX4_EN  defined   -> modified Booth radix-4, WIDTH/2 steps
//                    undefined -> radix-2 Booth, WIDTH steps (default)
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset
//   start    in   operation request, sampled only while idle
//   a        in   signed multiplicand [WIDTH-1:0]
//   b        in   signed multiplier   [WIDTH-1:0]
//   product  out  signed registered result [2*WIDTH-1:0]
//   done     out  one-cycle pulse: product has just been updated
//   busy     out  high while an operation is in flight; this is also the
//                 FSM state indicator (busy == state is CALC)
//
// Handshake:
//   start is accepted on any rising edge where the unit is idle and start=1;
//   a/b are captured on that edge and busy rises. start while busy is
//   ignored (no queueing). On the final step's edge product is loaded, done
//   pulses for exactly one cycle and busy falls. Holding start high issues a
//   new operation on the edge right after done.
// ---------------------------------------------------------------------------
module booth_mul #(
   parameter int WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic signed [WIDTH-1:0]   a,
   input  logic signed [WIDTH-1:0]   b,
   output logic signed [2*WIDTH-1:0] product,
   output logic                      done,
   output logic                      busy
);

`ifdef BOOTH_RADIX4_EN
   // Two extra accumulator bits so that +/-2M never overflows.
   localparam int ACC_W = WIDTH + 2;
   localparam int STEPS = WIDTH / 2;
`else
   // One extra accumulator bit so that -(-2^(WIDTH-1)) fits.
   localparam int ACC_W = WIDTH + 1;
   localparam int STEPS = WIDTH;
`endif
   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_CALC = 1'b1
   } state_t;

   state_t r_state;
   state_t w_next_state;

   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] r_m;
   logic [WIDTH-1:0] r_q;
   logic             r_q_m1;
   logic [CNT_W-1:0] r_cnt;
   logic             r_done;
   logic [2*WIDTH-1:0] r_product;

   logic             w_accept;
   logic             w_last;
   logic [ACC_W-1:0] w_sum;
   logic [ACC_W-1:0] w_acc_nxt;
   logic [WIDTH-1:0] w_q_nxt;
   logic             w_q_m1_nxt;

   // -----------------------------------------------------------------------
   // FSM: state register
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // -----------------------------------------------------------------------
   // FSM: next state and control strobes
   // -----------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_last       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_next_state = S_CALC;
            end
         end
         S_CALC: begin
            if (r_cnt == CNT_W'(STEPS - 1)) begin
               w_last       = 1'b1;
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // -----------------------------------------------------------------------
   // One Booth step: add/subtract from recoding, then arithmetic shift
   // -----------------------------------------------------------------------
`ifdef BOOTH_RADIX4_EN
   logic [ACC_W-1:0] w_m2;
   assign w_m2 = {r_m[ACC_W-2:0], 1'b0};

   always_comb begin
      w_sum = r_acc;
      unique case ({r_q[1], r_q[0], r_q_m1})
         3'b001, 3'b010: w_sum = r_acc + r_m;
         3'b011:         w_sum = r_acc + w_m2;
         3'b100:         w_sum = r_acc - w_m2;
         3'b101, 3'b110: w_sum = r_acc - r_m;
         default:        w_sum = r_acc;   // 000 / 111
      endcase
      // Shift right by 2, replicating the accumulator sign bit.
      {w_acc_nxt, w_q_nxt, w_q_m1_nxt} = {{2{w_sum[ACC_W-1]}}, w_sum, r_q[WIDTH-1:1]};
   end
`else
   always_comb begin
      w_sum = r_acc;
      unique case ({r_q[0], r_q_m1})
         2'b01:   w_sum = r_acc + r_m;
         2'b10:   w_sum = r_acc - r_m;
         default: w_sum = r_acc;          // 00 / 11
      endcase
      // Shift right by 1, replicating the accumulator sign bit.
      {w_acc_nxt, w_q_nxt, w_q_m1_nxt} = {w_sum[ACC_W-1], w_sum, r_q};
   end
`endif

   // -----------------------------------------------------------------------
   // Datapath registers
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc     <= '0;
         r_m       <= '0;
         r_q       <= '0;
         r_q_m1    <= 1'b0;
         r_cnt     <= '0;
         r_done    <= 1'b0;
         r_product <= '0;
      end else begin
         // done is a single-cycle pulse; it is only set on a final step.
         r_done <= 1'b0;
         if (w_accept) begin
            r_m    <= {{(ACC_W - WIDTH){a[WIDTH-1]}}, a};
            r_q    <= b;
            r_acc  <= '0;
            r_q_m1 <= 1'b0;
            r_cnt  <= '0;
         end else if (r_state == S_CALC) begin
            r_acc  <= w_acc_nxt;
            r_q    <= w_q_nxt;
            r_q_m1 <= w_q_m1_nxt;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (w_last) begin
               // Low 2*WIDTH bits of {Acc, Q} after the last shift.
               r_product <= {w_acc_nxt[WIDTH-1:0], w_q_nxt};
               r_done    <= 1'b1;
            end
         end
      end
   end

   assign product = r_product;
   assign done    = r_done;
   assign busy    = (r_state == S_CALC);

endmodule

// File: tb/tb_booth_mul.sv
// ---------------------------------------------------------------------------
// tb_booth_mul -- self-checking bench for booth_mul (WIDTH = 8)
//
// Stimulus tasks issue operations and push the expected product (plain
// integer multiplication) into exp_q; a monitor on the falling edge pops
// and compares whenever done is seen, and also checks latency, the done
// pulse width, busy at done, and that product holds between results.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_booth_mul;

`ifdef BOOTH_RADIX4_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 8;
`endif

   // ---------------- clock / reset ----------------
   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               start = 1'b0;
   logic signed [7:0]  a = '0;
   logic signed [7:0]  b = '0;
   logic signed [15:0] product;
   logic               done;
   logic               busy;

   always #5 clk = ~clk;

   booth_mul #(.WIDTH(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .a       (a),
      .b       (b),
      .product (product),
      .done    (done),
      .busy    (busy)
   );

   int cyc = 0;
   always @(posedge clk) cyc++;

   // ---------------- scoreboard state ----------------
   logic [15:0] exp_q[$];
   int          acc_q[$];
   int          done_cyc_q[$];
   int          checks = 0;
   int          errors = 0;
   int          n_done = 0;
   logic [15:0] last_prod = '0;
   logic        prev_done = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: plain signed multiplication, truncated to 16 bits.
   function automatic logic [15:0] ref_mul(input int x, input int y);
      int p;
      p = x * y;
      return p[15:0];
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (reset) begin
         last_prod = '0;
         prev_done = 1'b0;
      end else begin
         if (done) begin
            n_done++;
            done_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               logic [15:0] e;
               int          ac;
               e  = exp_q.pop_front();
               ac = acc_q.pop_front();
               check("product", $signed(product), $signed(e));
               check("latency", cyc - ac, LAT);
               check("busy_at_done", busy, 0);
            end
            check("done_width", prev_done, 0);
            last_prod = product;
         end else begin
            if (product != last_prod)
               check("product_hold", $signed(product), $signed(last_prod));
         end
         prev_done = done;
      end
   end

   // ---------------- driver tasks ----------------
   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int x, input int y);
      exp_q.push_back(ref_mul(x, y));
      acc_q.push_back(cyc);
   endtask

   task automatic wait_done(input int base, input int target);
      for (int i = 0; i < 40 && n_done < base + target; i++) step();
      if (n_done < base + target) check("done_timeout", n_done - base, target);
   endtask

   // Issue one operation (unit must be idle) and wait for its result.
   task automatic do_op(input int x, input int y);
      int base;
      base  = n_done;
      start = 1'b1;
      a     = 8'(x);
      b     = 8'(y);
      step();
      push_exp(x, y);
      start = 1'b0;
      check("busy_after_accept", busy, 1);
      wait_done(base, 1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int base;
      int sa [9] = '{-25, 25, -25, 0, 5, -128, 127, 127, -128};
      int sb [9] = '{  5, -5,  -5, 5, 0, -128, -128, 127,   7};

      // Reset held two cycles.
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_product", product, 0);
      check("reset_done", done, 0);
      check("reset_busy", busy, 0);
      step();

      // Basic and sign/extreme cases.
      do_op(25, 5);
      for (int i = 0; i < 9; i++) do_op(sa[i], sb[i]);

      // Second start at E3 is ignored.
      base  = n_done;
      start = 1'b1; a = 8'sd54; b = 8'sd7;
      step();                               // E0
      push_exp(54, 7);
      start = 1'b0;
      step(); step();                       // E1, E2
      start = 1'b1; a = 8'sd3; b = 8'sd3;
      step();                               // E3
      start = 1'b0;
      check("busy_ignored_start", busy, 1);
      wait_done(base, 1);
      repeat (12) step();
      check("single_done_count", n_done - base, 1);
      check("product_378", product, 378);

      // Reset at E4 discards the operation.
      base  = n_done;
      start = 1'b1; a = -8'sd54; b = 8'sd7;
      step();                               // E0
      push_exp(-54, 7);
      start = 1'b0;
      repeat (3) step();                    // E1..E3
      reset = 1'b1;
      exp_q.delete();
      acc_q.delete();
      step();                               // E4 samples reset
      reset = 1'b0;
      repeat (12) step();
      check("no_done_after_reset", n_done - base, 0);
      check("product_after_reset", product, 0);
      check("busy_after_reset", busy, 0);
      do_op(6, 7);

      // start held high: three back-to-back operations.
      begin
         int ha [3] = '{2, -4, 6};
         int hb [3] = '{3, 5, -7};
         base = n_done;
         done_cyc_q.delete();
         start = 1'b1; a = 8'(ha[0]); b = 8'(hb[0]);
         for (int k = 0; k < 3; k++) begin
            step();                         // accepting edge
            push_exp(ha[k], hb[k]);
            if (k < 2) begin
               a = 8'(ha[k+1]);
               b = 8'(hb[k+1]);
               repeat (LAT) step();
            end else begin
               start = 1'b0;
            end
         end
         wait_done(base, 3);
         check("held_done_count", done_cyc_q.size(), 3);
         if (done_cyc_q.size() == 3) begin
            check("held_interval_1", done_cyc_q[1] - done_cyc_q[0], LAT + 1);
            check("held_interval_2", done_cyc_q[2] - done_cyc_q[1], LAT + 1);
         end
      end

      // Randomized operations with random idle gaps.
      for (int i = 0; i < 40; i++) begin
         int x, y;
         x = int'($urandom_range(0, 255)) - 128;
         y = int'($urandom_range(0, 255)) - 128;
         repeat ($urandom_range(0, 3)) step();
         do_op(x, y);
      end

      repeat (4) step();
      check("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
